// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Shares the common data bus between the ALU and the load/store buffer.
// Each producer has a small FIFO behind a valid/ready handshake; one result
// per cycle is granted round-robin and broadcast on registered CDB outputs.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rdy                   global enable; low freezes every register
//   rollback              synchronous flush from the ROB
//   alu_valid/tag/data    ALU result offer; alu_ready = accepted when valid
//   lsb_valid/tag/data    LSB result offer; lsb_ready = accepted when valid
//   cdb_valid/tag/data    registered broadcast
//   cdb_src               registered source of the broadcast (0 ALU, 1 LSB)
module cdb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              lsb_valid,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_data,
    output logic              lsb_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_src
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // index 0 = ALU, index 1 = LSB throughout
    logic [TAG_W-1:0]  mem_tag  [2][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [2][FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr   [2];
    logic [PW-1:0]     wr_ptr   [2];
    logic [CW-1:0]     cnt      [2];
    logic              prio;

    logic [1:0]        in_valid;
    logic [TAG_W-1:0]  in_tag  [2];
    logic [DATA_W-1:0] in_data [2];
    logic [1:0]        ready;
    logic [1:0]        acc;
    logic [1:0]        has_q;
    logic [1:0]        cand;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              grant;
    logic              win;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    always_comb begin
        in_valid   = {lsb_valid, alu_valid};
        in_tag[0]  = alu_tag;
        in_tag[1]  = lsb_tag;
        in_data[0] = alu_data;
        in_data[1] = lsb_data;
    end

    // acc is "accepted and worth keeping": tag 0 offers are taken but dropped.
    always_comb begin
        ready = '0;
        acc   = '0;
        has_q = '0;
        cand  = '0;
        for (int s = 0; s < 2; s++) begin
            ready[s] = rst_n && rdy && !rollback && (cnt[s] < DEPTH_C);
            acc[s]   = in_valid[s] && ready[s] && (in_tag[s] != '0);
            has_q[s] = (cnt[s] != '0);
            cand[s]  = has_q[s] || acc[s];
        end
    end

    always_comb begin
        grant = |cand;
        win   = (&cand) ? prio : cand[1];
        pop   = '0;
        push  = '0;
        for (int s = 0; s < 2; s++) begin
            pop[s]  = grant && (win == 1'(s)) && has_q[s];
            // an accepted offer is queued unless it went straight out as bypass
            push[s] = acc[s] && !(grant && (win == 1'(s)) && !has_q[s]);
        end
        win_tag  = has_q[win] ? mem_tag[win][rd_ptr[win]]  : in_tag[win];
        win_data = has_q[win] ? mem_data[win][rd_ptr[win]] : in_data[win];
    end

    assign alu_ready = ready[0];
    assign lsb_ready = ready[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            prio      <= 1'b0;
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_data  <= '0;
            cdb_src   <= 1'b0;
        end else if (rollback) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            prio      <= 1'b0;
            cdb_valid <= 1'b0;
        end else if (rdy) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
                if (push[s] && !pop[s])
                    cnt[s] <= cnt[s] + CW'(1);
                else if (pop[s] && !push[s])
                    cnt[s] <= cnt[s] - CW'(1);
            end
            cdb_valid <= grant;
            if (grant) begin
                cdb_tag  <= win_tag;
                cdb_data <= win_data;
                cdb_src  <= win;
                prio     <= ~win;
            end
        end
    end

    // storage needs no reset; push is already qualified by rst_n, rdy, rollback
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                mem_tag[s][wr_ptr[s]]  <= in_tag[s];
                mem_data[s][wr_ptr[s]] <= in_data[s];
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, rdy = 1'b1, rollback = 1'b0;
    logic        alu_valid = 1'b0, lsb_valid = 1'b0;
    logic [3:0]  alu_tag = '0, lsb_tag = '0;
    logic [31:0] alu_data = '0, lsb_data = '0;
    logic        alu_ready, lsb_ready;
    logic        cdb_valid, cdb_src;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;

    cdb_arbiter #(.DATA_W(32), .TAG_W(4), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
        .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_data(lsb_data), .lsb_ready(lsb_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    logic [37:0] cdb_act;
    assign cdb_act = {cdb_valid, cdb_src, cdb_tag, cdb_data};

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: one queue per producer, broadcast register, priority
    typedef struct packed { logic [3:0] tag; logic [31:0] data; } ent_t;
    ent_t        qa[$];
    ent_t        ql[$];
    int          m_prio = 0;
    logic [37:0] m_exp = '0;
    logic [1:0]  e_ready;

    // Queue-level view: an accepted offer joins the back of its queue; the
    // candidate is whatever sits at the front, so bypass falls out naturally.
    task automatic model_step();
        ent_t e;
        int   w;
        bit   ha, hl;
        if (!rst_n) begin
            qa.delete(); ql.delete(); m_prio = 0; m_exp = '0;
        end else if (rollback) begin
            qa.delete(); ql.delete(); m_prio = 0; m_exp[37] = 1'b0;
        end else if (rdy) begin
            if (alu_valid && qa.size() < DEPTH && alu_tag != 0) qa.push_back({alu_tag, alu_data});
            if (lsb_valid && ql.size() < DEPTH && lsb_tag != 0) ql.push_back({lsb_tag, lsb_data});
            ha = qa.size() > 0;
            hl = ql.size() > 0;
            if (ha || hl) begin
                w = (ha && hl) ? m_prio : (hl ? 1 : 0);
                if (w == 0) e = qa.pop_front(); else e = ql.pop_front();
                m_exp  = {1'b1, (w == 1), e.tag, e.data};
                m_prio = 1 - w;
            end else begin
                m_exp[37] = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic r_n, input logic en, input logic rb,
                         input logic av, input logic [3:0] at, input logic [31:0] ad,
                         input logic lv, input logic [3:0] lt, input logic [31:0] ld);
        @(negedge clk);
        rst_n = r_n; rdy = en; rollback = rb;
        alu_valid = av; alu_tag = at; alu_data = ad;
        lsb_valid = lv; lsb_tag = lt; lsb_data = ld;
        #1;
        e_ready[0] = r_n && en && !rb && (qa.size() < DEPTH);
        e_ready[1] = r_n && en && !rb && (ql.size() < DEPTH);
    endtask

    task automatic drive_rand(input logic r_n, input logic en, input logic rb,
                              input int pct, input bit nz);
        logic [3:0] ta, tl;
        ta = 4'($urandom_range(nz ? 1 : 0, 15));
        tl = 4'($urandom_range(nz ? 1 : 0, 15));
        drive(r_n, en, rb, ($urandom_range(0, 99) < pct), ta, $urandom,
              ($urandom_range(0, 99) < pct), tl, $urandom);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1, 1, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
    endtask

    task automatic do_reset();
        drive(0, 1, 0, 0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive_rand(0, i[0], 0, 100, 1);
            n_checks++;
            if ({lsb_ready, alu_ready} !== 2'b00) $display("FAIL reset_ready: got %b expected 00", {lsb_ready, alu_ready});
            else n_pass++;
            tick();
            n_checks++;
            if (cdb_act !== 38'd0) $display("FAIL reset_cdb: got %h expected 0", cdb_act);
            else n_pass++;
        end
    endtask

    task automatic test_isolated_alu();
        do_reset();
        drive(1, 1, 0, 1, 4'd3, 32'h11, 0, 4'd0, 32'd0);
        n_checks++;
        if (alu_ready !== 1'b1) $display("FAIL iso_ready: got %b expected 1", alu_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (cdb_act !== {1'b1, 1'b0, 4'd3, 32'h11}) $display("FAIL iso_bcast: got %h expected %h", cdb_act, {1'b1, 1'b0, 4'd3, 32'h11});
        else n_pass++;
        idle(); tick();
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL iso_idle: got %b expected 0", cdb_valid);
        else n_pass++;
    endtask

    task automatic test_tie();
        do_reset();
        drive(1, 1, 0, 1, 4'd1, 32'hA, 1, 4'd2, 32'hB);
        n_checks++;
        if ({lsb_ready, alu_ready} !== 2'b11) $display("FAIL tie_ready: got %b expected 11", {lsb_ready, alu_ready});
        else n_pass++;
        tick();
        n_checks++;
        if (cdb_act !== {1'b1, 1'b0, 4'd1, 32'hA}) $display("FAIL tie_first: got %h expected %h", cdb_act, {1'b1, 1'b0, 4'd1, 32'hA});
        else n_pass++;
        idle(); tick();
        n_checks++;
        if (cdb_act !== {1'b1, 1'b1, 4'd2, 32'hB}) $display("FAIL tie_second: got %h expected %h", cdb_act, {1'b1, 1'b1, 4'd2, 32'hB});
        else n_pass++;
        idle(); tick();
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL tie_idle: got %b expected 0", cdb_valid);
        else n_pass++;
        // prio must be back at ALU: a fresh tie goes to the ALU again
        drive(1, 1, 0, 1, 4'd5, 32'h55, 1, 4'd6, 32'h66);
        tick();
        n_checks++;
        if (cdb_act !== {1'b1, 1'b0, 4'd5, 32'h55}) $display("FAIL tie_prio_back: got %h expected %h", cdb_act, {1'b1, 1'b0, 4'd5, 32'h55});
        else n_pass++;
        idle(); tick();
    endtask

    task automatic test_tag0();
        do_reset();
        drive(1, 1, 0, 1, 4'd0, 32'h55, 0, 4'd0, 32'd0);
        n_checks++;
        if (alu_ready !== 1'b1) $display("FAIL tag0_ready: got %b expected 1", alu_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL tag0_nobcast: got %b expected 0", cdb_valid);
        else n_pass++;
        // ALU FIFO must still be empty: a new offer bypasses straight out
        drive(1, 1, 0, 1, 4'd7, 32'h77, 0, 4'd0, 32'd0);
        tick();
        n_checks++;
        if (cdb_act !== {1'b1, 1'b0, 4'd7, 32'h77}) $display("FAIL tag0_notqueued: got %h expected %h", cdb_act, {1'b1, 1'b0, 4'd7, 32'h77});
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic prev_src;
        do_reset();
        prev_src = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_rand(1, 1, 0, 100, 1);
            n_checks++;
            if ({lsb_ready, alu_ready} !== e_ready) $display("FAIL sat_ready cyc %0d: got %b expected %b", i, {lsb_ready, alu_ready}, e_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (cdb_act !== m_exp) $display("FAIL sat_cdb cyc %0d: got %h expected %h", i, cdb_act, m_exp);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (cdb_valid !== 1'b1 || cdb_src !== ~prev_src) $display("FAIL sat_alternate cyc %0d: got v%b src%b expected v1 src%b", i, cdb_valid, cdb_src, ~prev_src);
                else n_pass++;
            end
            prev_src = cdb_src;
        end
        for (int i = 0; i < 5; i++) begin
            idle();
            tick();
            n_checks++;
            if (cdb_act !== m_exp) $display("FAIL sat_drain cyc %0d: got %h expected %h", i, cdb_act, m_exp);
            else n_pass++;
        end
    endtask

    task automatic test_rollback();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_rand(1, 1, 0, 100, 1);
            tick();
            n_checks++;
            if (cdb_act !== m_exp) $display("FAIL rb_fill cyc %0d: got %h expected %h", i, cdb_act, m_exp);
            else n_pass++;
        end
        drive_rand(1, 1, 1, 100, 1);
        n_checks++;
        if ({lsb_ready, alu_ready} !== 2'b00) $display("FAIL rb_ready_low: got %b expected 00", {lsb_ready, alu_ready});
        else n_pass++;
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL rb_cdb_clear: got %b expected 0", cdb_valid);
        else n_pass++;
        idle();
        n_checks++;
        if ({lsb_ready, alu_ready} !== 2'b11) $display("FAIL rb_ready_back: got %b expected 11", {lsb_ready, alu_ready});
        else n_pass++;
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL rb_no_stale: got %b expected 0", cdb_valid);
        else n_pass++;
    endtask

    task automatic test_rdy_stall();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i >= 3 && i < 6) drive_rand(1, 0, 0, 100, 1);
            else if (i < 9)      drive_rand(1, 1, 0, 100, 1);
            else                 idle();
            n_checks++;
            if ({lsb_ready, alu_ready} !== e_ready) $display("FAIL stall_ready cyc %0d: got %b expected %b", i, {lsb_ready, alu_ready}, e_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (cdb_act !== m_exp) $display("FAIL stall_cdb cyc %0d: got %h expected %h", i, cdb_act, m_exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_rand(1, 1, 0, 100, 1);
            tick();
        end
        drive_rand(0, 1, 0, 100, 1);
        n_checks++;
        if ({lsb_ready, alu_ready} !== 2'b00) $display("FAIL rstmid_ready: got %b expected 00", {lsb_ready, alu_ready});
        else n_pass++;
        tick();
        n_checks++;
        if (cdb_act !== 38'd0) $display("FAIL rstmid_cdb: got %h expected 0", cdb_act);
        else n_pass++;
        idle();
        n_checks++;
        if ({lsb_ready, alu_ready} !== 2'b11) $display("FAIL rstmid_ready_back: got %b expected 11", {lsb_ready, alu_ready});
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive_rand(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 99) < 3), 60, 0);
            n_checks++;
            if ({lsb_ready, alu_ready} !== e_ready) $display("FAIL rand_ready cyc %0d: got %b expected %b", i, {lsb_ready, alu_ready}, e_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (cdb_act !== m_exp) $display("FAIL rand_cdb cyc %0d: got %h expected %h", i, cdb_act, m_exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_isolated_alu();
        test_tie();
        test_tag0();
        test_saturation();
        test_rollback();
        test_rdy_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
